// File: rtl/imm_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_encoder_pkg
//
// Shared definitions for the immediate encoder slice.
//   - imm_type_e   : immediate format selector. The encoding matches the
//                    existing immediate decoder (J=00, I=01, S=10, B=11).
//   - occ_state_e  : occupancy of the two-entry output stage.
//   - enc_entry_t  : one stored result (encoded instruction + error flag).
//   - width constants and the sign-extension masks used by the range check.
//   - bits_uniform : helper that tells whether all masked bits are equal.
//
// Optional feature macro used by the files that import this package:
//   IMM_RANGE_CHECK_EN
// -----------------------------------------------------------------------------
package imm_encoder_pkg;

    localparam int XLEN      = 32;
    localparam int ENC_CNT_W = 16;
    localparam int ERR_CNT_W = 8;

    // Bits that must be a pure sign extension for each format to be
    // representable. I and S carry a 12-bit signed field (bits 31..11 equal),
    // B carries a 13-bit signed field (bits 31..12 equal) and J a 21-bit
    // signed field (bits 31..20 equal).
    localparam logic [XLEN-1:0] IS_SIGN_MASK = 32'hFFFF_F800;
    localparam logic [XLEN-1:0] B_SIGN_MASK  = 32'hFFFF_F000;
    localparam logic [XLEN-1:0] J_SIGN_MASK  = 32'hFFF0_0000;

    typedef enum logic [1:0] {
        IMM_J = 2'b00,
        IMM_I = 2'b01,
        IMM_S = 2'b10,
        IMM_B = 2'b11
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            err;
    } enc_entry_t;

    // True when every bit selected by mask has the same value in v,
    // i.e. the selected bits are either all zero or all one.
    function automatic logic bits_uniform(input logic [XLEN-1:0] v,
                                          input logic [XLEN-1:0] mask);
        logic [XLEN-1:0] sel;
        sel = v & mask;
        return (sel == '0) || (sel == mask);
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
//
// Purely combinational packing of a signed immediate into an instruction
// template, plus the optional representability check.
//
// Ports:
//   imm_type  in  2   immediate format (imm_type_e)
//   imm       in  32  signed immediate / byte offset
//   base      in  32  instruction template; non-immediate bits pass through
//   instr     out 32  template with the immediate fields overwritten
//   err       out 1   immediate not representable in imm_type
//
// Configuration:
//   IMM_RANGE_CHECK_EN  defined   -> err reflects the range/alignment check
//                       undefined -> err is tied to 0, no check logic exists
//
// The immediate fields are always filled from the truncated immediate bits,
// even when err is raised, so a consumer sees a deterministic encoding.
// -----------------------------------------------------------------------------
module imm_pack
    import imm_encoder_pkg::*;
(
    input  imm_type_e       imm_type,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] base,
    output logic [XLEN-1:0] instr,
    output logic            err
);

    // Field scatter: start from the template and overwrite only the bit
    // positions that the selected format uses for its immediate. B and J
    // drop imm[0] because those offsets are always even.
    always_comb begin
        instr = base;
        case (imm_type)
            IMM_I: begin
                instr[31:20] = imm[11:0];
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Representability check: the bits above the format's signed field must
    // be a clean sign extension, and branch/jump offsets must be even.
    always_comb begin
        err = 1'b0;
        case (imm_type)
            IMM_I, IMM_S: err = !bits_uniform(imm, IS_SIGN_MASK);
            IMM_B:        err = !bits_uniform(imm, B_SIGN_MASK) || imm[0];
            IMM_J:        err = !bits_uniform(imm, J_SIGN_MASK) || imm[0];
        endcase
    end
`else
    // Without the check the upper immediate bits feed nothing; they are
    // gathered into a named sink so the absence is explicit.
    logic unused_imm_high;
    assign unused_imm_high = ^imm[31:21];
    assign err             = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Encodes a signed immediate into an instruction template behind a
// valid/ready handshake on both sides. One imm_pack instance does the field
// packing at the input; results are held in a two-entry FIFO made of an
// output register and one skid register.
//
// Ports:
//   clk        in  1   clock, all state on the rising edge
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   request present
//   in_ready   out 1   request can be accepted (registered: skid empty)
//   in_type    in  2   format: 01 I, 10 S, 11 B, 00 J
//   in_imm     in  32  signed immediate
//   in_base    in  32  instruction template
//   out_valid  out 1   encoded instruction present
//   out_ready  in  1   consumer accepts this cycle
//   out_instr  out 32  encoded instruction
//   out_err    out 1   immediate was not representable
//   enc_count  out 16  accepted-request counter (wraps)
//   err_count  out 8   erroneous-request counter (saturates)
//
// Configuration:
//   IMM_RANGE_CHECK_EN  enables the range check and err_count; when undefined
//                       out_err and err_count are constant 0.
//
// Latency is one cycle: an entry accepted on an edge is visible on out_*
// right after that edge whenever the output register is empty or draining.
// -----------------------------------------------------------------------------
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_type,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_instr,
    output logic                 out_err,
    output logic [ENC_CNT_W-1:0] enc_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    occ_state_e state_q;
    occ_state_e state_d;

    enc_entry_t out_q;
    enc_entry_t skid_q;
    enc_entry_t new_entry;

    logic [XLEN-1:0] pack_instr;
    logic            pack_err;
    logic            in_ready_q;
    logic            accept;
    logic            drain;
    logic            load_out_new;
    logic            load_out_skid;
    logic            load_skid;

    imm_pack u_pack (
        .imm_type (imm_type_e'(in_type)),
        .imm      (in_imm),
        .base     (in_base),
        .instr    (pack_instr),
        .err      (pack_err)
    );

    assign new_entry = '{instr: pack_instr, err: pack_err};

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_instr = out_q.instr;
    assign out_err   = out_q.err;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid && out_ready;

    // Occupancy next-state and data-path steering. The output register is
    // always the FIFO head; the skid register only ever holds the second,
    // younger entry. When the head drains while a new entry arrives in ONE,
    // the new entry goes straight to the output register so there is no
    // bubble. In TWO nothing can arrive because in_ready is already low.
    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d      = OCC_ONE;
                    load_out_new = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_d   = OCC_TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (drain) begin
                    state_d       = OCC_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
    end

    // State register. in_ready is registered from the next state so that it
    // is high exactly when the skid register will be empty, with no
    // combinational path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_TWO);
        end
    end

    // Entry storage. Reset clears both entries so nothing stale can appear
    // after a reset that interrupted a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_new) begin
                out_q <= new_entry;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    // Accepted-request counter; natural wrap at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= '0;
        end else if (accept) begin
            enc_count <= enc_count + 1'b1;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    // Error counter: counts accepted requests flagged by the range check and
    // sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && pack_err && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Self-checking bench for imm_encoder: a table of directed encode vectors
// with hand-computed results, then hand-written sequences for back-pressure
// ordering, reset while full, and error-counter saturation.
// Expected error values follow IMM_RANGE_CHECK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [1:0] T_J = 2'b00;
    localparam logic [1:0] T_I = 2'b01;
    localparam logic [1:0] T_S = 2'b10;
    localparam logic [1:0] T_B = 2'b11;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int vec_count;
    int miss_count;
    int exp_enc;
    int exp_errc;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[12];

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a miscompare on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents one request starting at a falling edge, waits (bounded) for
    // in_ready, lets it be accepted on the next rising edge and returns at
    // the following falling edge with in_valid dropped.
    task automatic applyStimulus(input logic [1:0] typ, input logic [31:0] imm,
                                 input logic [31:0] base);
        int waited;
        waited   = 0;
        in_type  = typ;
        in_imm   = imm;
        in_base  = base;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_enc  = 0;
        exp_errc = 0;
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        exp_enc    = 0;
        exp_errc   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_type    = T_I;
        in_imm     = '0;
        in_base    = '0;
        out_ready  = 1'b1;

        vecs[0]  = '{T_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0, "i_minus1"};
        vecs[1]  = '{T_S, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 1'b0, "s_plus8"};
        vecs[2]  = '{T_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, "b_minus4"};
        vecs[3]  = '{T_J, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0, "j_2048"};
        vecs[4]  = '{T_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, "i_overflow"};
        vecs[5]  = '{T_S, 32'hFFFF_FFF0, 32'h0000_2023, 32'hFE00_2823, 1'b0, "s_minus16"};
        vecs[6]  = '{T_B, 32'h0000_0001, 32'h0000_0063, 32'h0000_0063, 1'b1, "b_odd"};
        vecs[7]  = '{T_J, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1, "j_overflow"};
        vecs[8]  = '{T_I, 32'h0000_07FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, "i_max_base"};
        vecs[9]  = '{T_J, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_F000, 1'b0, "j_minus2"};
        vecs[10] = '{T_B, 32'h0000_1000, 32'h0000_0000, 32'h8000_0000, 1'b1, "b_overflow"};
        vecs[11] = '{T_S, 32'h0000_0000, 32'hFE00_0F80, 32'h0000_0000, 1'b0, "s_clear"};

        // Values while reset is held.
        @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("rst_out_instr", out_instr,          32'd0);
        checkOutput("rst_out_err",   {31'd0, out_err},   32'd0);
        checkOutput("rst_enc_count", {16'd0, enc_count}, 32'd0);
        checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed encode table, one request at a time with the consumer ready.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].typ, vecs[i].imm, vecs[i].base);
            exp_enc++;
            if (RANGE_CHECK && vecs[i].exp_err && exp_errc < 255) exp_errc++;
            checkOutput({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            checkOutput({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
            checkOutput({vecs[i].name, "_err"}, {31'd0, out_err},
                        {31'd0, RANGE_CHECK & vecs[i].exp_err});
            checkOutput({vecs[i].name, "_enc_count"}, {16'd0, enc_count}, exp_enc);
            checkOutput({vecs[i].name, "_err_count"}, {24'd0, err_count}, exp_errc);
        end
        @(negedge clk);
        checkOutput("table_drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: three back-to-back requests with the consumer stalled.
        doReset();
        out_ready = 1'b0;
        in_type   = T_I;
        in_base   = 32'h0000_0013;
        in_imm    = 32'h0000_0001;
        in_valid  = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
        in_imm = 32'h0000_0002;
        @(posedge clk); @(negedge clk);
        checkOutput("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_head_a",        out_instr,         32'h0010_0013);
        in_imm = 32'h0000_0003;
        @(posedge clk); @(negedge clk);
        checkOutput("bp_c_held_off",    {31'd0, in_ready}, 32'd0);
        checkOutput("bp_a_stable",      out_instr,         32'h0010_0013);
        checkOutput("bp_enc_two",       {16'd0, enc_count}, 32'd2);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("bp_b_valid",       {31'd0, out_valid}, 32'd1);
        checkOutput("bp_b_instr",       out_instr,          32'h0020_0013);
        checkOutput("bp_ready_reopen",  {31'd0, in_ready},  32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_c_valid",       {31'd0, out_valid}, 32'd1);
        checkOutput("bp_c_instr",       out_instr,          32'h0030_0013);
        @(posedge clk); @(negedge clk);
        checkOutput("bp_empty",         {31'd0, out_valid}, 32'd0);
        checkOutput("bp_enc_three",     {16'd0, enc_count}, 32'd3);

        // Reset while both entries are occupied.
        doReset();
        out_ready = 1'b0;
        in_type   = T_S;
        in_base   = 32'h0000_2023;
        in_imm    = 32'h0000_0008;
        in_valid  = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("mid_rst_out_instr", out_instr,          32'd0);
        checkOutput("mid_rst_enc_count", {16'd0, enc_count}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        checkOutput("post_rst_idle", {31'd0, out_valid}, 32'd0);
        applyStimulus(T_J, 32'h0000_0800, 32'h0000_006F);
        checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("post_rst_instr", out_instr,          32'h0010_006F);
        checkOutput("post_rst_enc",   {16'd0, enc_count}, 32'd1);
        @(negedge clk);

        // 300 overflowing requests streamed with the consumer always ready.
        doReset();
        out_ready = 1'b1;
        in_type   = T_I;
        in_imm    = 32'h0000_0800;
        in_base   = 32'h0000_0013;
        in_valid  = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("sat_enc_count", {16'd0, enc_count}, 32'd300);
        checkOutput("sat_err_count", {24'd0, err_count}, RANGE_CHECK ? 32'd255 : 32'd0);
        checkOutput("sat_last_err",  {31'd0, out_err},   {31'd0, RANGE_CHECK});
        checkOutput("sat_last_instr", out_instr,         32'h8000_0013);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
